// File: rtl/spi_adc_sequencer.sv
// Mode-0 SPI master for a 16-bit ADC: arbitrates host config writes against
// periodic sample reads and hands received samples downstream with a strobe.
module spi_adc_sequencer #(
  parameter int CLK_DIV       = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int CS_SETUP      = 1,
  parameter int CS_HOLD       = 1,
  parameter int GAP_CYCLES    = 2,
  parameter int SAMPLE_PERIOD = 100
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iCFG_REQ,
  input  logic [15:0] iCFG_WORD,
  output logic        oCFG_ACK,
  input  logic        iSAMPLE_EN,
  output logic [15:0] oSAMPLE,
  output logic        oSAMPLE_VALID,
  output logic        oOVERRUN,
  output logic        oBUSY,
  output logic        oCS_n,
  output logic        oSCK,
  output logic        oMOSI,
  input  logic        iMISO
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HIGH_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] BIT_LAST   = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] HALF       = 16'(CLK_DIV);

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [15:0]            tx_q, tx_d;
  logic [15:0]            rx_q, rx_d;
  logic                   isCfg_q, isCfg_d;
  logic [15:0]            sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   ack_q, ack_d;
  logic                   overrun_q, overrun_d;
  logic [PW-1:0]          period_q, period_d;
  logic                   pending_q, pending_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   misoSync;
  logic                   take;
  logic                   tick;
  logic                   startSlot;

  assign misoSync = sync_q[SYNC_STAGES-1];

  // The last GAP cycle doubles as the IDLE decision so queued frames run
  // back-to-back with exactly GAP_CYCLES of CS high between them.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    isCfg_d   = isCfg_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    ack_d     = 1'b0;
    take      = 1'b0;
    startSlot = (state_q == IDLE) || ((state_q == GAP) && (cnt_q == GAP_LAST));
    if (startSlot) begin
      cnt_d = '0;
      if (iCFG_REQ) begin
        state_d = SETUP;
        tx_d    = iCFG_WORD;
        isCfg_d = 1'b1;
      end else if (pending_q && iSAMPLE_EN) begin
        state_d = SETUP;
        tx_d    = '0;
        isCfg_d = 1'b0;
        take    = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_d = SHIFT;
            cnt_d   = '0;
            bit_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        SHIFT: begin
          if (cnt_q == HIGH_LAST) begin
            rx_d  = {rx_q[14:0], misoSync};
            tx_d  = {tx_q[14:0], 1'b0};
            cnt_d = cnt_q + 16'd1;
          end else if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (bit_q == 4'd15) begin
              state_d = HOLD;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
            if (isCfg_q) begin
              ack_d = 1'b1;
            end else begin
              sample_d = rx_q;
              valid_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        GAP:     cnt_d = cnt_q + 16'd1;
        default: state_d = IDLE;
      endcase
    end
  end

  // A tick landing while the previous one is still unserved is dropped.
  always_comb begin
    tick      = iSAMPLE_EN && (period_q == PERIOD_LAST);
    period_d  = period_q + PW'(1);
    pending_d = pending_q;
    overrun_d = 1'b0;
    if (!iSAMPLE_EN) begin
      period_d  = '0;
      pending_d = 1'b0;
    end else if (tick) begin
      period_d  = '0;
      pending_d = 1'b1;
      overrun_d = pending_q && !take;
    end else if (take) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      isCfg_q   <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      overrun_q <= 1'b0;
      period_q  <= '0;
      pending_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      isCfg_q   <= isCfg_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      ack_q     <= ack_d;
      overrun_q <= overrun_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], iMISO};
    end
  end

  assign oCFG_ACK      = ack_q;
  assign oSAMPLE_VALID = valid_q;
  assign oOVERRUN      = overrun_q;
  assign oSAMPLE       = sample_q;
  assign oBUSY         = (state_q != IDLE);
  assign oCS_n         = !((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD));
  assign oSCK          = (state_q == SHIFT) && (cnt_q < HALF);
  assign oMOSI         = ((state_q == SETUP) || (state_q == SHIFT)) && tx_q[15];

endmodule

// File: tb/tb_spi_adc_sequencer.sv
// Self-checking bench: scoreboarded config/sample frames on a default instance,
// plus a short-period instance exercising overrun and disable behaviour.
module tb_spi_adc_sequencer;

  typedef struct {
    bit          isCfg;
    logic [15:0] word;
    logic [15:0] slave;
    logic [15:0] expMosi;
    logic [15:0] expSample;
  } vec_t;

  typedef struct {
    bit          isCfg;
    logic [15:0] mosi;
    logic [15:0] data;
  } exp_t;

  localparam logic [15:0] SLAVE_B = 16'h6D29;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cfgReq;
  logic [15:0] cfgWord;
  logic        sampleEnA, sampleEnB;
  logic        ackA, validA, ovrA, busyA, csA, sckA, mosiA, misoA;
  logic [15:0] sampleA;
  logic        ackB, validB, ovrB, busyB, csB, sckB, mosiB, misoB;
  logic [15:0] sampleB;
  logic [15:0] slaveWordA;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t sbq[$];
  int   fallQ[$];
  vec_t vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_adc_sequencer dutA (
    .iCLK(clk), .iRST_n(rstN), .iCFG_REQ(cfgReq), .iCFG_WORD(cfgWord),
    .oCFG_ACK(ackA), .iSAMPLE_EN(sampleEnA), .oSAMPLE(sampleA),
    .oSAMPLE_VALID(validA), .oOVERRUN(ovrA), .oBUSY(busyA), .oCS_n(csA),
    .oSCK(sckA), .oMOSI(mosiA), .iMISO(misoA)
  );

  spi_adc_sequencer #(.SAMPLE_PERIOD(40)) dutB (
    .iCLK(clk), .iRST_n(rstN), .iCFG_REQ(1'b0), .iCFG_WORD(16'h0000),
    .oCFG_ACK(ackB), .iSAMPLE_EN(sampleEnB), .oSAMPLE(sampleB),
    .oSAMPLE_VALID(validB), .oOVERRUN(ovrB), .oBUSY(busyB), .oCS_n(csB),
    .oSCK(sckB), .oMOSI(mosiB), .iMISO(misoB)
  );

  // Slave models: present MSB when CS falls, advance on every SCK falling edge.
  int fallCntA = 0;
  int fallCntB = 0;
  always @(negedge sckA or posedge csA) begin
    if (csA) fallCntA = 0;
    else fallCntA++;
  end
  always @(negedge sckB or posedge csB) begin
    if (csB) fallCntB = 0;
    else fallCntB++;
  end
  assign misoA = (!csA && fallCntA < 16) ? slaveWordA[4'(15 - fallCntA)] : 1'b0;
  assign misoB = (!csB && fallCntB < 16) ? SLAVE_B[4'(15 - fallCntB)] : 1'b0;

  // Records what the master drives on MOSI at each SCK rising edge of a frame.
  logic [15:0] mosiWordA = '0;
  int          sckCntA = 0;
  always @(posedge sckA or negedge csA) begin
    if (!sckA) begin
      mosiWordA = '0;
      sckCntA   = 0;
    end else begin
      mosiWordA = {mosiWordA[14:0], mosiA};
      sckCntA++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor A: pops the scoreboard on every ACK/VALID strobe.
  bit          prevCsA = 1'b1;
  int          csLowRunA = 0;
  int          lastCsLowA = 0;
  int          ackCntA = 0;
  int          ovrCntA = 0;
  logic [15:0] lastSample = '0;
  exp_t        curExp;
  always @(negedge clk) begin
    if (!rstN) begin
      prevCsA    = 1'b1;
      csLowRunA  = 0;
      lastSample = '0;
    end else begin
      if (!csA) csLowRunA++;
      if (csA && !prevCsA) begin
        lastCsLowA = csLowRunA;
        csLowRunA  = 0;
      end
      if (!csA && prevCsA) fallQ.push_back(cyc);
      if (ovrA) ovrCntA++;
      if (ackA) ackCntA++;
      if (ackA || validA) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedStrobe: ack=%0b valid=%0b with nothing expected", ackA, validA);
        end else begin
          curExp = sbq.pop_front();
          checkOutput("strobeKind", {ackA, validA}, curExp.isCfg ? 2'b10 : 2'b01);
          checkOutput("strobeOnCsRise", {prevCsA, csA}, 2'b01);
          checkOutput("csLowLength", lastCsLowA, 66);
          checkOutput("sckPulses", sckCntA, 16);
          checkOutput("mosiWord", mosiWordA, curExp.mosi);
          if (curExp.isCfg) begin
            checkOutput("sampleHeld", sampleA, lastSample);
          end else begin
            checkOutput("sampleData", sampleA, curExp.data);
            lastSample = curExp.data;
          end
        end
      end
      prevCsA = csA;
    end
  end

  // Monitor B: frame spacing, data, and counts for the short-period instance.
  bit prevCsB = 1'b1;
  int highRunB = 0;
  int framesB = 0;
  int validsB = 0;
  int ovrCntB = 0;
  int badB = 0;
  always @(negedge clk) begin
    if (rstN) begin
      if (csB) begin
        highRunB++;
      end else if (prevCsB) begin
        if (framesB > 0) checkOutput("gapB", highRunB, 2);
        framesB++;
        highRunB = 0;
      end
      if (validB) begin
        validsB++;
        checkOutput("sampleB", sampleB, SLAVE_B);
      end
      if (ovrB) ovrCntB++;
      if (ackB || mosiB || (!csB && !busyB)) badB++;
      prevCsB = csB;
    end
  end

  task automatic waitAck(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ackA) begin ok = 1'b1; break; end
    end
    checkOutput("ackArrived", ok, 1'b1);
  endtask

  task automatic waitValid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (validA) begin ok = 1'b1; break; end
    end
    checkOutput("validArrived", ok, 1'b1);
  endtask

  task automatic waitCsFall(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!csA) begin ok = 1'b1; break; end
    end
    checkOutput("csFell", ok, 1'b1);
  endtask

  task automatic applyStimulus(input vec_t v);
    bit   ok;
    exp_t e;
    slaveWordA = v.slave;
    e.isCfg    = v.isCfg;
    e.mosi     = v.isCfg ? v.expMosi : 16'h0000;
    e.data     = v.expSample;
    sbq.push_back(e);
    @(negedge clk);
    if (v.isCfg) begin
      cfgWord = v.word;
      cfgReq  = 1'b1;
      waitCsFall(50, ok);
      cfgWord = ~v.word;
      waitAck(300, ok);
      cfgReq = 1'b0;
    end else begin
      sampleEnA = 1'b1;
      waitValid(300, ok);
      sampleEnA = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_cs"}, csA, 1'b1);
    checkOutput({tag, "_sck"}, sckA, 1'b0);
    checkOutput({tag, "_mosi"}, mosiA, 1'b0);
    checkOutput({tag, "_valid"}, validA, 1'b0);
    checkOutput({tag, "_ack"}, ackA, 1'b0);
    checkOutput({tag, "_ovr"}, ovrA, 1'b0);
    checkOutput({tag, "_busy"}, busyA, 1'b0);
    checkOutput({tag, "_sample"}, sampleA, 16'h0000);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit   ok;
    exp_t e;
    int   base, n, startsAtDisable, tickSum;

    rstN = 1'b0; cfgReq = 1'b0; cfgWord = '0;
    sampleEnA = 1'b0; sampleEnB = 1'b0; slaveWordA = '0;

    vecs[0] = '{1'b1, 16'h2A00, 16'hFFFF, 16'h2A00, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 16'hA5C3, 16'h0000, 16'hA5C3};
    vecs[2] = '{1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b0, 16'h0000, 16'h0001, 16'h0000, 16'h0001};
    vecs[4] = '{1'b1, 16'h8001, 16'h5555, 16'h8001, 16'h0000};
    vecs[5] = '{1'b0, 16'h0000, 16'h8000, 16'h0000, 16'h8000};
    vecs[6] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};

    repeat (3) @(negedge clk);
    checkResetState("initReset");
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    $display("[TB] periodic sampling");
    slaveWordA = 16'hA5C3;
    e.isCfg = 1'b0; e.mosi = 16'h0000; e.data = 16'hA5C3;
    for (int i = 0; i < 3; i++) sbq.push_back(e);
    base = fallQ.size();
    @(negedge clk);
    sampleEnA = 1'b1;
    for (int i = 0; i < 3; i++) waitValid(300, ok);
    sampleEnA = 1'b0;
    checkOutput("periodFrames", fallQ.size() - base, 3);
    if (fallQ.size() - base == 3) begin
      checkOutput("period1", fallQ[base+1] - fallQ[base], 100);
      checkOutput("period2", fallQ[base+2] - fallQ[base+1], 100);
    end
    repeat (5) @(negedge clk);

    $display("[TB] config and tick collision");
    slaveWordA = 16'h3C3C;
    e.isCfg = 1'b1; e.mosi = 16'h1357; e.data = 16'h0000;
    sbq.push_back(e);
    e.isCfg = 1'b0; e.mosi = 16'h0000; e.data = 16'h3C3C;
    sbq.push_back(e);
    @(negedge clk);
    sampleEnA = 1'b1;
    repeat (99) @(posedge clk);
    @(negedge clk);
    cfgWord = 16'h1357;
    cfgReq  = 1'b1;
    waitAck(300, ok);
    cfgReq = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!csA) begin n = i; break; end
    end
    checkOutput("collisionGap", n, 2);
    waitValid(300, ok);
    sampleEnA = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] overrun and disable");
    @(negedge clk);
    sampleEnB = 1'b1;
    repeat (400) @(posedge clk);
    @(negedge clk);
    sampleEnB = 1'b0;
    startsAtDisable = framesB;
    repeat (100) @(negedge clk);
    checkOutput("disableCompletes", validsB, startsAtDisable);
    checkOutput("noStartAfterDisable", framesB, startsAtDisable);
    repeat (200) @(negedge clk);
    checkOutput("stillStopped", framesB, startsAtDisable);
    checkOutput("overrunSeen", ovrCntB > 0, 1'b1);
    tickSum = validsB + ovrCntB;
    checkOutput("tickAccounting", (tickSum == 9) || (tickSum == 10), 1'b1);

    $display("[TB] reset during shift");
    @(negedge clk);
    cfgWord = 16'hBEEF;
    cfgReq  = 1'b1;
    waitCsFall(50, ok);
    repeat (20) @(posedge clk);
    #3 rstN = 1'b0;
    #1 checkResetState("midFrameReset");
    cfgReq = 1'b0;
    n = ackCntA;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (150) @(negedge clk);
    checkOutput("noAckAfterAbort", ackCntA, n);
    checkOutput("idleAfterAbort", busyA, 1'b0);

    applyStimulus(vecs[0]);

    checkOutput("noOverrunA", ovrCntA, 0);
    checkOutput("instanceBClean", badB, 0);
    checkOutput("scoreboardDrained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
